// File: rtl/vga_pixel_fetch_pkg.sv
// Shared screen constants, pixel classes and helpers for vga_pixel_fetch.
// Counter width is derived from the 800x525 total raster.
package vga_pixel_fetch_pkg;

  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int SCR_HTOT = 800;
  localparam int SCR_VTOT = 525;
  localparam int LATCH_LINE = 480;
  localparam int CNT_W =
    $clog2(SCR_HTOT > SCR_VTOT ? SCR_HTOT : SCR_VTOT);

  typedef enum logic [1:0] {
    CLS_IMG = 2'd0,
    CLS_BRD = 2'd1,
    CLS_BLK = 2'd2
  } pix_class_e;

  localparam logic [7:0] RGB_BLACK = 8'h00;

  function automatic pix_class_e classify(
    input logic [CNT_W-1:0] h,
    input logic [CNT_W-1:0] v,
    input int win_w,
    input int win_h
  );
    int hi;
    int vi;
    hi = int'(h);
    vi = int'(v);
    if (hi < win_w && vi < win_h) return CLS_IMG;
    if (hi < SCR_W && vi < SCR_H) return CLS_BRD;
    return CLS_BLK;
  endfunction

endpackage

// File: rtl/vga_pixel_fetch_delay_pipe.sv
// fetch_delay_pipe: fixed-depth register line, async active-low clear.
// DEPTH of 0 degenerates to a plain wire.
module fetch_delay_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stg [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
      end else begin
        stg[0] <= d;
        for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
      end
    end

    assign q = stg[DEPTH-1];
  end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Counter-to-colour fetch stage with scroll, upscale, tiling and border.
// Optional test pattern input enabled by VGA_PIXEL_FETCH_TESTPAT_EN.
module vga_pixel_fetch
  import vga_pixel_fetch_pkg::*;
#(
  parameter int FB_W_BITS   = 8,
  parameter int FB_H_BITS   = 8,
  parameter int SCALE_SHIFT = 1,
  parameter int WIN_WIDTH   = 512,
  parameter int WIN_HEIGHT  = 480,
  parameter int RAM_LATENCY = 2,
  parameter int PIXEL_DELAY = 7
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [CNT_W-1:0]               count_h,
  input  logic [CNT_W-1:0]               count_v,
  input  logic [FB_W_BITS-1:0]           scroll_x,
  input  logic [FB_H_BITS-1:0]           scroll_y,
  input  logic [7:0]                     border_color,
`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
  input  logic                           test_mode,
`endif
  output logic [FB_W_BITS+FB_H_BITS-1:0] rd_addr,
  input  logic [7:0]                     rd_data,
  output logic [7:0]                     color,
  output logic                           frame_latch
);

`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
  localparam int TW = 12;
`else
  localparam int TW = 3;
`endif
  localparam int PAD = PIXEL_DELAY - (RAM_LATENCY + 3);

  logic [FB_W_BITS-1:0] sh_sx;
  logic [FB_H_BITS-1:0] sh_sy;
  logic [7:0]           sh_border;
  logic                 capture;

  assign capture = (count_h == '0) &&
                   (int'(count_v) == LATCH_LINE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_sx       <= '0;
      sh_sy       <= '0;
      sh_border   <= '0;
      frame_latch <= 1'b0;
    end else begin
      frame_latch <= capture;
      if (capture) begin
        sh_sx     <= scroll_x;
        sh_sy     <= scroll_y;
        sh_border <= border_color;
      end
    end
  end

  logic [CNT_W-1:0] h1;
  logic [CNT_W-1:0] v1;
  pix_class_e       cls1;
  logic             vld1;
`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
  logic             tm1;
  logic [7:0]       pat1;
`endif

  // vld1 keeps freshly reset pipe slots black regardless of rd_data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h1   <= '0;
      v1   <= '0;
      cls1 <= CLS_IMG;
      vld1 <= 1'b0;
`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
      tm1  <= 1'b0;
      pat1 <= '0;
`endif
    end else begin
      h1   <= count_h;
      v1   <= count_v;
      cls1 <= classify(count_h, count_v, WIN_WIDTH, WIN_HEIGHT);
      vld1 <= 1'b1;
`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
      tm1  <= test_mode;
      pat1 <= count_h[7:0] ^ count_v[7:0];
`endif
    end
  end

  logic [CNT_W-1:0]     hs;
  logic [CNT_W-1:0]     vs;
  logic [FB_W_BITS-1:0] fb_x;
  logic [FB_H_BITS-1:0] fb_y;
  logic [TW-1:0]        tag1;
  logic [TW-1:0]        tag2;
  logic [TW-1:0]        tag_d;

  assign hs   = h1 >> SCALE_SHIFT;
  assign vs   = v1 >> SCALE_SHIFT;
  assign fb_x = FB_W_BITS'(hs) + sh_sx;
  assign fb_y = FB_H_BITS'(vs) + sh_sy;

`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
  assign tag1 = {vld1, cls1, tm1, pat1};
`else
  assign tag1 = {vld1, cls1};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr <= '0;
      tag2    <= '0;
    end else begin
      rd_addr <= {fb_y, fb_x};
      tag2    <= tag1;
    end
  end

  fetch_delay_pipe #(
    .WIDTH(TW),
    .DEPTH(RAM_LATENCY)
  ) u_cls_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (tag2),
    .q       (tag_d)
  );

  logic       vld_d;
  pix_class_e cls_d;
  logic [7:0] img;

  assign vld_d = tag_d[TW-1];
  assign cls_d = pix_class_e'(tag_d[TW-2 -: 2]);
`ifdef VGA_PIXEL_FETCH_TESTPAT_EN
  assign img = tag_d[8] ? tag_d[7:0] : rd_data;
`else
  assign img = rd_data;
`endif

  logic [7:0] pix_nxt;
  logic [7:0] pix3;

  always_comb begin
    pix_nxt = RGB_BLACK;
    if (vld_d) begin
      unique case (1'b1)
        (cls_d == CLS_IMG): pix_nxt = img;
        (cls_d == CLS_BRD): pix_nxt = sh_border;
        default:            pix_nxt = RGB_BLACK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pix3 <= RGB_BLACK;
    else          pix3 <= pix_nxt;
  end

  fetch_delay_pipe #(
    .WIDTH(8),
    .DEPTH(PAD)
  ) u_pad_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pix3),
    .q       (color)
  );

endmodule
